// File: rtl/ex_stage.sv
// ex_stage: execute stage that muxes ALU operands, resolves branches from ALU flags
// and captures results into a two-entry skid buffer with a registered in_ready.
module ex_stage #(
  parameter int DATA_W = 32,
  parameter int REG_W = 5,
  parameter int ALU_OP_W = 4,
  parameter logic [ALU_OP_W-1:0] ALU_XOR = ALU_OP_W'(4),
  parameter logic [ALU_OP_W-1:0] ALU_SLT = ALU_OP_W'(8),
  parameter logic [ALU_OP_W-1:0] ALU_SLTU = ALU_OP_W'(9)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                flush,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [DATA_W-1:0]   in_pc,
  input  logic [DATA_W-1:0]   in_rs1,
  input  logic [DATA_W-1:0]   in_rs2,
  input  logic [DATA_W-1:0]   in_imm,
  input  logic                in_a_sel,
  input  logic                in_b_sel,
  input  logic [ALU_OP_W-1:0] in_alu_op,
  input  logic [2:0]          in_br,
  input  logic [REG_W-1:0]    in_rd,
  output logic [DATA_W-1:0]   alu_a,
  output logic [DATA_W-1:0]   alu_b,
  output logic [ALU_OP_W-1:0] alu_op,
  input  logic [DATA_W-1:0]   alu_eval,
  input  logic                alu_zero,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [DATA_W-1:0]   out_result,
  output logic [REG_W-1:0]    out_rd,
  output logic                out_br_taken,
  output logic [DATA_W-1:0]   out_br_target
);
  typedef struct packed {
    logic [DATA_W-1:0] result;
    logic [REG_W-1:0]  rd;
    logic              taken;
    logic [DATA_W-1:0] target;
  } ent_t;
  typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;
  state_t r_state;
  ent_t r_head, r_tail;
  logic r_in_ready;
  logic w_is_br, w_taken, w_accept, w_drain;
  logic [DATA_W-1:0] w_target;
  ent_t w_new;
  assign w_is_br = (in_br != 3'd0) && (in_br != 3'd7);
  assign alu_a = (w_is_br || !in_a_sel) ? in_rs1 : in_pc;
  assign alu_b = (w_is_br || !in_b_sel) ? in_rs2 : in_imm;
  assign alu_op = (in_br == 3'd1 || in_br == 3'd2) ? ALU_XOR :
                  (in_br == 3'd3 || in_br == 3'd4) ? ALU_SLT :
                  (in_br == 3'd5 || in_br == 3'd6) ? ALU_SLTU : in_alu_op;
  always_comb begin
    w_taken = (in_br == 3'd1) ? alu_zero :
              (in_br == 3'd2) ? !alu_zero :
              (in_br == 3'd3 || in_br == 3'd5) ? alu_eval[0] :
              (in_br == 3'd4 || in_br == 3'd6) ? !alu_eval[0] : 1'b0;
  end
  assign w_target = in_pc + in_imm;
  assign w_new = {alu_eval, in_rd, w_taken, w_target};
  assign w_accept = in_valid && r_in_ready;
  assign w_drain = out_valid && out_ready;
  // in_ready is low only while both entries are occupied
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= EMPTY;
      r_in_ready <= 1'b1;
      r_head <= '0;
      r_tail <= '0;
    end else if (flush) begin
      r_state <= EMPTY;
      r_in_ready <= 1'b1;
    end else begin
      case (r_state)
        EMPTY: if (w_accept) begin
          r_state <= ONE;
          r_head <= w_new;
        end
        ONE: if (w_accept && w_drain) r_head <= w_new;
        else if (w_accept) begin
          r_state <= TWO;
          r_tail <= w_new;
          r_in_ready <= 1'b0;
        end else if (w_drain) r_state <= EMPTY;
        TWO: if (w_drain) begin
          r_state <= ONE;
          r_head <= r_tail;
          r_in_ready <= 1'b1;
        end
        default: r_state <= EMPTY;
      endcase
    end
  end
  assign in_ready = r_in_ready;
  assign out_valid = r_state != EMPTY;
  assign out_result = r_head.result;
  assign out_rd = r_head.rd;
  assign out_br_taken = r_head.taken;
  assign out_br_target = r_head.target;
endmodule

// File: tb/tb_ex_stage.sv
// tb_ex_stage: directed and random checks of ex_stage against a queue-based model
// with an ALU model attached to the stage's ALU port.
module tb_ex_stage;
  localparam logic [3:0] OP_ADD = 0, OP_SUB = 1, OP_AND = 2, OP_OR = 3, OP_XOR = 4;
  localparam logic [3:0] OP_SLL = 5, OP_SRL = 6, OP_SRA = 7, OP_SLT = 8, OP_SLTU = 9;
  typedef struct packed {
    logic [31:0] pc, rs1, rs2, imm;
    logic a_sel, b_sel;
    logic [3:0] op;
    logic [2:0] br;
    logic [4:0] rd;
  } ins_t;
  typedef struct packed {
    logic [31:0] result;
    logic [4:0] rd;
    logic taken;
    logic [31:0] target;
  } ent_t;
  logic clk = 0, rst_n, flush, in_valid, in_ready, out_valid, out_ready;
  logic [31:0] alu_a, alu_b, alu_eval, out_result, out_br_target;
  logic [3:0] alu_op;
  logic alu_zero, out_br_taken;
  logic [4:0] out_rd;
  ins_t cur;
  ent_t q[$];
  logic m_rdy;
  int n_err = 0, n_chk = 0, n_acc = 0;
  always #5 clk = ~clk;
  ex_stage dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_pc(cur.pc), .in_rs1(cur.rs1), .in_rs2(cur.rs2), .in_imm(cur.imm),
    .in_a_sel(cur.a_sel), .in_b_sel(cur.b_sel), .in_alu_op(cur.op), .in_br(cur.br),
    .in_rd(cur.rd), .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_eval(alu_eval),
    .alu_zero(alu_zero), .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_rd(out_rd), .out_br_taken(out_br_taken),
    .out_br_target(out_br_target)
  );
  function automatic logic [31:0] alu_f(input logic [31:0] a, input logic [31:0] b, input logic [3:0] op);
    case (op)
      OP_ADD: return a + b;
      OP_SUB: return a - b;
      OP_AND: return a & b;
      OP_OR: return a | b;
      OP_XOR: return a ^ b;
      OP_SLL: return a << b[4:0];
      OP_SRL: return a >> b[4:0];
      OP_SRA: return $unsigned($signed(a) >>> b[4:0]);
      OP_SLT: return {31'd0, $signed(a) < $signed(b)};
      OP_SLTU: return {31'd0, a < b};
      default: return 32'd0;
    endcase
  endfunction
  always_comb begin
    alu_eval = alu_f(alu_a, alu_b, alu_op);
    alu_zero = (alu_eval == 32'd0);
  end
  function automatic logic is_br(input ins_t i);
    return i.br >= 3'd1 && i.br <= 3'd6;
  endfunction
  function automatic logic [31:0] exp_a(input ins_t i);
    return is_br(i) ? i.rs1 : (i.a_sel ? i.pc : i.rs1);
  endfunction
  function automatic logic [31:0] exp_b(input ins_t i);
    return is_br(i) ? i.rs2 : (i.b_sel ? i.imm : i.rs2);
  endfunction
  function automatic logic [3:0] exp_op(input ins_t i);
    case (i.br)
      3'd1, 3'd2: return OP_XOR;
      3'd3, 3'd4: return OP_SLT;
      3'd5, 3'd6: return OP_SLTU;
      default: return i.op;
    endcase
  endfunction
  function automatic ent_t exp_ent(input ins_t i);
    ent_t e;
    e.result = alu_f(exp_a(i), exp_b(i), exp_op(i));
    e.rd = i.rd;
    e.target = i.pc + i.imm;
    case (i.br)
      3'd1: e.taken = i.rs1 == i.rs2;
      3'd2: e.taken = i.rs1 != i.rs2;
      3'd3: e.taken = $signed(i.rs1) < $signed(i.rs2);
      3'd4: e.taken = $signed(i.rs1) >= $signed(i.rs2);
      3'd5: e.taken = i.rs1 < i.rs2;
      3'd6: e.taken = i.rs1 >= i.rs2;
      default: e.taken = 1'b0;
    endcase
    return e;
  endfunction
  function automatic ins_t mk(input logic [31:0] pc, rs1, rs2, imm, input logic [3:0] op, input logic [2:0] br, input logic [4:0] rd);
    ins_t i;
    i = '{pc: pc, rs1: rs1, rs2: rs2, imm: imm, a_sel: 1'b0, b_sel: 1'b0, op: op, br: br, rd: rd};
    return i;
  endfunction
  function automatic ins_t rnd();
    ins_t i;
    i.pc = $urandom;
    i.rs1 = $urandom;
    i.rs2 = ($urandom_range(0, 3) == 0) ? i.rs1 : $urandom;
    i.imm = $urandom;
    i.a_sel = 1'($urandom);
    i.b_sel = 1'($urandom);
    i.op = 4'($urandom_range(0, 9));
    i.br = 3'($urandom_range(0, 7));
    i.rd = 5'($urandom);
    return i;
  endfunction
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic chk_reset(input string tag);
    chk({tag, "_valid"}, out_valid, 0);
    chk({tag, "_ready"}, in_ready, 1);
    chk({tag, "_result"}, out_result, 0);
    chk({tag, "_rd"}, out_rd, 0);
    chk({tag, "_taken"}, out_br_taken, 0);
    chk({tag, "_target"}, out_br_target, 0);
  endtask
  // Called one time unit after a rising edge with the cycle's inputs already applied.
  task automatic tick();
    logic acc, drn;
    ent_t e;
    #1;
    chk("alu_a", alu_a, exp_a(cur));
    chk("alu_b", alu_b, exp_b(cur));
    chk("alu_op", alu_op, exp_op(cur));
    chk("in_ready", in_ready, m_rdy);
    chk("out_valid", out_valid, q.size() != 0);
    if (q.size() != 0) begin
      chk("out_result", out_result, q[0].result);
      chk("out_rd", out_rd, q[0].rd);
      chk("out_taken", out_br_taken, q[0].taken);
      chk("out_target", out_br_target, q[0].target);
    end
    acc = in_valid && m_rdy;
    drn = (q.size() != 0) && out_ready;
    e = exp_ent(cur);
    if (in_valid && in_ready) n_acc++;
    @(posedge clk);
    #1;
    if (flush) q.delete();
    else begin
      if (drn) void'(q.pop_front());
      if (acc) q.push_back(e);
    end
    m_rdy = q.size() < 2;
  endtask
  initial begin
    cur = '0; in_valid = 0; out_ready = 1; flush = 0; rst_n = 0; m_rdy = 1;
    repeat (2) @(posedge clk);
    #1;
    chk_reset("rst");
    rst_n = 1;
    cur = mk(0, 5, 7, 0, OP_ADD, 0, 3);
    in_valid = 1;
    #1 chk("add_op", alu_op, OP_ADD);
    tick();
    in_valid = 0;
    chk("add_valid", out_valid, 1);
    chk("add_result", out_result, 12);
    chk("add_rd", out_rd, 3);
    chk("add_taken", out_br_taken, 0);
    tick();
    cur = mk(32'h100, 32'hFFFF_FFFF, 1, 32'hFFFF_FFF0, OP_ADD, 3, 1);
    in_valid = 1;
    #1 chk("lt_op", alu_op, OP_SLT);
    tick();
    chk("lt_taken", out_br_taken, 1);
    chk("lt_target", out_br_target, 32'hF0);
    cur.br = 5;
    #1 chk("ltu_op", alu_op, OP_SLTU);
    tick();
    chk("ltu_taken", out_br_taken, 0);
    chk("ltu_target", out_br_target, 32'hF0);
    cur = mk(0, 32'h55, 32'h55, 0, OP_ADD, 1, 2);
    tick();
    chk("eq_taken", out_br_taken, 1);
    cur.br = 2;
    tick();
    chk("ne_taken", out_br_taken, 0);
    cur = mk(32'hFFFF_FFFC, 1, 2, 8, OP_SUB, 0, 4);
    tick();
    chk("wrap_target", out_br_target, 4);
    in_valid = 0;
    tick();
    out_ready = 0;
    n_acc = 0;
    for (int i = 0; i < 4; i++) begin
      cur = rnd();
      in_valid = 1;
      tick();
    end
    chk("bp_accepts", n_acc, 2);
    chk("bp_ready_low", in_ready, 0);
    in_valid = 0;
    out_ready = 1;
    repeat (3) tick();
    chk("bp_ready_back", in_ready, 1);
    chk("bp_empty", out_valid, 0);
    out_ready = 0;
    for (int i = 0; i < 2; i++) begin
      cur = rnd();
      in_valid = 1;
      tick();
    end
    cur = rnd();
    flush = 1;
    tick();
    flush = 0;
    in_valid = 0;
    chk("flush_valid", out_valid, 0);
    chk("flush_ready", in_ready, 1);
    out_ready = 1;
    repeat (2) tick();
    out_ready = 0;
    cur = rnd();
    in_valid = 1;
    tick();
    in_valid = 0;
    chk("one_valid", out_valid, 1);
    rst_n = 0;
    #1;
    chk_reset("arst");
    q.delete();
    m_rdy = 1;
    @(posedge clk);
    #1 rst_n = 1;
    for (int i = 0; i < 400; i++) begin
      cur = rnd();
      in_valid = $urandom_range(0, 3) != 0;
      out_ready = $urandom_range(0, 2) != 0;
      flush = $urandom_range(0, 24) == 0;
      tick();
    end
    flush = 0;
    in_valid = 0;
    out_ready = 1;
    repeat (3) tick();
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
